// File: rtl/fir_filter_direct_form.sv
// Direct-form FIR filter with a registered, saturated output.
// The tap-0 term uses the live input sample, so y[n] appears one clock after x[n].
module fir_filter_direct_form #(
    parameter int                          NUM_TAPS   = 8,
    parameter int                          DATA_W     = 32,
    parameter int                          COEFF_W    = 16,
    parameter int                          COEFF_FRAC = 0,
    parameter logic [NUM_TAPS*COEFF_W-1:0] COEFFS     = (NUM_TAPS*COEFF_W)'(1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] incoming_signal_x,
    output logic signed [DATA_W-1:0] output_signal_y
);

    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
    localparam int DLY    = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] delay_q [DLY];
    logic signed [DATA_W-1:0] taps    [NUM_TAPS];
    logic signed [PROD_W-1:0] prod    [NUM_TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] y_d;
    logic signed [DATA_W-1:0] y_q;

    // delay_q[k-1] holds x[n-k]
    always_comb begin
        taps[0] = incoming_signal_x;
        for (int k = 1; k < NUM_TAPS; k++) begin
            taps[k] = delay_q[k-1];
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod[k] = PROD_W'(taps[k]) * PROD_W'($signed(COEFFS[k*COEFF_W +: COEFF_W]));
            acc     = acc + ACC_W'(prod[k]);
        end
    end

    // Arithmetic shift floors toward negative infinity before clamping to the output range
    always_comb begin
        shifted = acc >>> COEFF_FRAC;
        if (shifted > SAT_MAX) begin
            y_d = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y_d = SAT_MIN[DATA_W-1:0];
        end else begin
            y_d = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
            for (int k = 0; k < DLY; k++) begin
                delay_q[k] <= '0;
            end
        end else begin
            y_q        <= y_d;
            delay_q[0] <= incoming_signal_x;
            for (int k = 1; k < DLY; k++) begin
                delay_q[k] <= delay_q[k-1];
            end
        end
    end

    assign output_signal_y = y_q;

endmodule

// File: tb/tb_fir_filter_direct_form.sv
// Bench for fir_filter_direct_form: four instances (identity, ramp coefficients, all-2 saturation,
// fractional shift) checked every cycle against a convolution model plus hand-computed vectors.
module tb_fir_filter_direct_form;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] xv [4];
    logic [31:0] yv [4];

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    // Sample history since the last reset: hist[i][k] is x[n-k]; zeros stand for pre-reset samples
    longint      hist [4][8];
    longint      coef [4][8];
    int          frac [4];
    logic [31:0] expY [4];

    always #5 clk = ~clk;

    fir_filter_direct_form dutId (
        .clk(clk), .reset(reset), .incoming_signal_x(xv[0]), .output_signal_y(yv[0])
    );

    fir_filter_direct_form #(
        .COEFFS(128'h0008_0007_0006_0005_0004_0003_0002_0001)
    ) dutRamp (
        .clk(clk), .reset(reset), .incoming_signal_x(xv[1]), .output_signal_y(yv[1])
    );

    fir_filter_direct_form #(
        .COEFFS(128'h0002_0002_0002_0002_0002_0002_0002_0002)
    ) dutSat (
        .clk(clk), .reset(reset), .incoming_signal_x(xv[2]), .output_signal_y(yv[2])
    );

    fir_filter_direct_form #(
        .COEFF_FRAC(1)
    ) dutFrac (
        .clk(clk), .reset(reset), .incoming_signal_x(xv[3]), .output_signal_y(yv[3])
    );

    // Plain convolution, floor division by 2^frac, then clamp to the signed 32-bit range
    function automatic logic [31:0] modelOut(input int i);
        longint acc;
        longint maxV;
        longint minV;
        maxV = 64'sd2147483647;
        minV = -maxV - 1;
        acc  = 0;
        for (int k = 0; k < 8; k++) begin
            acc += coef[i][k] * hist[i][k];
        end
        acc = acc >>> frac[i];
        if (acc > maxV) acc = maxV;
        else if (acc < minV) acc = minV;
        return acc[31:0];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) hist[i][k] = 0;
            expY[i] = '0;
        end
    endtask

    // One clock: the edge consumes the current inputs, then the model absorbs the same samples
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = longint'($signed(xv[i]));
                expY[i]    = modelOut(i);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) xv[i] = '0;
        clearModel();
        applyStimulus();
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("model_y%0d", i), yv[i], expY[i]);
            end
        end
    end

    logic [31:0] idSeq   [7]  = '{32'd0, 32'd1, 32'd2, 32'd100, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] impExp  [10] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0, 32'd0};
    logic [31:0] stepExp [10] = '{32'd10, 32'd30, 32'd60, 32'd100, 32'd150, 32'd210, 32'd280, 32'd360, 32'd360, 32'd360};
    logic [31:0] fracIn  [4]  = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] fracExp [4]  = '{32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd0};

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xv[i]   = '0;
            frac[i] = 0;
            for (int k = 0; k < 8; k++) begin
                coef[0][k] = (k == 0) ? 1 : 0;
                coef[1][k] = k + 1;
                coef[2][k] = 2;
                coef[3][k] = (k == 0) ? 1 : 0;
            end
        end
        frac[3] = 1;
        clearModel();

        // Reset state
        applyStimulus();
        checkEn = 1'b1;
        for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_y%0d", i), yv[i], 32'd0);
        #1;
        reset = 1'b0;

        // Identity stream on the default instance, impulse on the ramp instance
        for (int j = 0; j < 10; j++) begin
            xv[0] = (j < 7) ? idSeq[j] : 32'd0;
            xv[1] = (j == 0) ? 32'd1 : 32'd0;
            applyStimulus();
            checkOutput("identity", yv[0], (j < 7) ? idSeq[j] : 32'd0);
            checkOutput("impulse", yv[1], impExp[j]);
        end

        // Step response; the first value after reset is b0*x alone
        doReset();
        xv[1] = 32'd10;
        for (int j = 0; j < 10; j++) begin
            applyStimulus();
            checkOutput("step", yv[1], stepExp[j]);
        end

        // Positive saturation alongside the fractional-shift vectors
        doReset();
        xv[2] = 32'h7FFF_FFFF;
        for (int j = 0; j < 8; j++) begin
            xv[3] = (j < 4) ? fracIn[j] : 32'd0;
            applyStimulus();
            checkOutput("sat_pos", yv[2], 32'h7FFF_FFFF);
            if (j < 4) checkOutput("frac", yv[3], fracExp[j]);
        end

        doReset();
        xv[2] = 32'h8000_0000;
        for (int j = 0; j < 8; j++) begin
            applyStimulus();
            checkOutput("sat_neg", yv[2], 32'h8000_0000);
        end

        // Asynchronous reset in the middle of an impulse response
        doReset();
        xv[1] = 32'd1;
        applyStimulus();
        xv[1] = 32'd0;
        applyStimulus();
        applyStimulus();
        checkOutput("pre_async", yv[1], 32'd3);
        #2;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("async_clear_ramp", yv[1], 32'd0);
        checkOutput("async_clear_sat", yv[2], 32'd0);
        xv[0] = 32'd5;
        xv[1] = 32'd5;
        applyStimulus();
        checkOutput("held_in_reset_id", yv[0], 32'd0);
        checkOutput("held_in_reset_ramp", yv[1], 32'd0);
        #2;
        reset = 1'b0;
        xv[0] = 32'd0;
        xv[1] = 32'd0;
        for (int j = 0; j < 5; j++) begin
            applyStimulus();
            checkOutput("post_reset_quiet", yv[1], 32'd0);
        end
        xv[1] = 32'd1;
        applyStimulus();
        checkOutput("post_reset_impulse", yv[1], 32'd1);
        xv[1] = 32'd0;
        applyStimulus();
        checkOutput("post_reset_impulse2", yv[1], 32'd2);

        @(negedge clk);
        #1;
        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fir_filter_direct_form.md
FIR_FILTER_DIRECT_FORM -- requirements
Module: fir_filter_direct_form

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL provide parameter NUM_TAPS, default 8: number of filter taps (b0..b(NUM_TAPS-1)); legal range 1..32.
REQ-002 SHALL provide parameter DATA_W, default 32: input/output sample width, signed two's complement.
REQ-003 SHALL provide parameter COEFF_W, default 16: width of each signed coefficient.
REQ-004 SHALL provide parameter COEFF_FRAC, default 0: fractional bits of coefficients; accumulator right-shifted (arithmetic) by this amount before output.
REQ-005 SHALL provide parameter COEFFS, packed NUM_TAPS*COEFF_W bits, default b0=1, all others 0: coefficient k at bits [k*COEFF_W +: COEFF_W].

Ports, one per line: name  direction  width  meaning (clock and reset first).
REQ-006 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL provide port incoming_signal_x  input  DATA_W  signed input sample x[n], sampled every rising clk edge.
REQ-009 SHALL provide port output_signal_y  output  DATA_W  signed, registered filter output y[n].

Function
REQ-010 SHALL accept one new sample on every rising clk edge while reset is low; no enable and no handshake.
REQ-011 SHALL hold a delay line d[1..NUM_TAPS-1] of DATA_W-bit registers; each edge: d[1] <= x, d[k] <= d[k-1].
REQ-012 SHALL compute acc = b0*x + sum over k=1..NUM_TAPS-1 of bk*d[k], using the current incoming_signal_x as the tap-0 term.
REQ-013 SHALL form each product at full signed width DATA_W+COEFF_W, with no truncation before accumulation.
REQ-014 SHALL accumulate at DATA_W+COEFF_W+ceil(log2(NUM_TAPS)) bits so that no intermediate overflow occurs.
REQ-015 SHALL arithmetic-shift acc right by COEFF_FRAC, truncating toward negative infinity.
REQ-016 SHALL saturate the shifted result to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before registering.
REQ-017 SHALL register the result into output_signal_y on the same edge that shifts the delay line.
REQ-018 Latency: y for sample x[n] presented before edge n SHALL appear on output_signal_y immediately after edge n, i.e. y[n] = sum bk*x[n-k] visible one cycle after x[n] is applied.
REQ-019 SHALL treat samples older than the last reset as zero, i.e. no contribution from pre-reset history.
REQ-020 With default COEFFS, output_signal_y SHALL equal incoming_signal_x delayed by exactly one clock, bit-exact, for all 32-bit values.
REQ-021 SHALL be fully synchronous apart from reset; no combinational path from incoming_signal_x to output_signal_y.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for clk, clear output_signal_y and all delay-line registers to 0.
REQ-023 While reset is high, all state SHALL stay 0 regardless of clk and incoming_signal_x.
REQ-024 On the first rising edge after reset deasserts, x SHALL be sampled normally and y SHALL equal b0*x (shifted and saturated).
REQ-025 Reset asserted mid-stream SHALL discard all history; the post-reset response SHALL match a freshly reset filter.

Verification
REQ-026 Identity, default COEFFS: stream 0,1,2,100,-5,32'h7FFFFFFF,32'h80000000 -> y reproduces the same sequence one cycle later, bit-exact.
REQ-027 Impulse, COEFFS = 1,2,3,4,5,6,7,8: x = 1 for one cycle then 0 -> y = 1,2,3,4,5,6,7,8 on successive cycles, then 0.
REQ-028 Step, same COEFFS: x held at 10 -> y = 10,30,60,100,150,210,280,360, then holds at 360.
REQ-029 Saturation, all coeffs = 2: x = 32'h7FFFFFFF held -> y = 32'h7FFFFFFF; x = 32'h80000000 held -> y = 32'h80000000.
REQ-030 Fractional, COEFF_FRAC = 1, b0 = 1, others 0: x = 7 -> y = 3; x = -7 -> y = -4.
REQ-031 Async reset, impulse COEFFS: assert reset mid-cycle between edges during nonzero output -> y = 0 at once, before the next edge; after release, y stays 0 until new nonzero input.
